// File: rtl/grf_trace_fifo_pkg.sv
// Shared trace-record layout for the GRF write trace FIFO.
// A record is {pc, addr, data}, with pc in the top bits.
package grf_trace_fifo_pkg;

   localparam int TR_PC_W = 32;
   localparam int TR_A_W  = 5;
   localparam int TR_D_W  = 32;
   localparam int TR_W    = TR_PC_W + TR_A_W + TR_D_W;

   localparam int TR_D_LSB  = 0;
   localparam int TR_D_MSB  = TR_D_LSB + TR_D_W - 1;
   localparam int TR_A_LSB  = TR_D_MSB + 1;
   localparam int TR_A_MSB  = TR_A_LSB + TR_A_W - 1;
   localparam int TR_PC_LSB = TR_A_MSB + 1;
   localparam int TR_PC_MSB = TR_PC_LSB + TR_PC_W - 1;

   // Writes to $0 are architecturally invisible and never traced.
   localparam logic [TR_A_W-1:0] GRF_ZERO = '0;

   typedef struct packed {
      logic [TR_PC_W-1:0] pc;
      logic [TR_A_W-1:0]  addr;
      logic [TR_D_W-1:0]  data;
   } trace_rec_t;

   function automatic logic [TR_W-1:0] tr_pack(
      input logic [TR_PC_W-1:0] pc,
      input logic [TR_A_W-1:0]  addr,
      input logic [TR_D_W-1:0]  data
   );
      return {pc, addr, data};
   endfunction

endpackage

// File: rtl/grf_trace_fifo_mem.sv
// Trace record storage: one synchronous write port, one asynchronous read port.
// Storage is deliberately left without reset.
module trace_fifo_mem
   import grf_trace_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [TR_W-1:0]   i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [TR_W-1:0]   o_rdata
);

   logic [TR_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/grf_trace_fifo.sv
// Captures non-$0 GRF writes as {pc, addr, data} records in a FWFT FIFO,
// with a sticky overflow flag and a saturating drop counter.
module grf_trace_fifo
   import grf_trace_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DROP_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_we,
   input  logic [TR_PC_W-1:0]  in_pc,
   input  logic [TR_A_W-1:0]   in_grfa,
   input  logic [TR_D_W-1:0]   in_grfw,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [TR_PC_W-1:0]  out_pc,
   output logic [TR_A_W-1:0]   out_grfa,
   output logic [TR_D_W-1:0]   out_grfw,
   output logic [ADDR_W:0]     count,
   output logic                overflow,
   output logic [DROP_W-1:0]   drop_cnt,
   input  logic                clr_ovf
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   generate
      if ((DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_bad_param
         $error("grf_trace_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
      end
   endgenerate

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_push_req;
   logic              w_full;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [TR_W-1:0]   w_wdata;
   logic [TR_W-1:0]   w_rdata;
   trace_rec_t        w_head;

   assign w_push_req = in_we && (in_grfa != GRF_ZERO);
   assign w_full     = (r_count == FULL_CNT);
   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid && out_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;
   assign w_wdata    = tr_pack(in_pc, in_grfa, in_grfw);

   trace_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // A drop in the same cycle as clr_ovf wins and restarts the count at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clr_ovf) begin
            r_drop_cnt <= DROP_W'(1);
         end else if (!(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   assign w_head    = trace_rec_t'(w_rdata);
   assign out_valid = w_valid;
   assign out_pc    = w_valid ? w_head.pc   : '0;
   assign out_grfa  = w_valid ? w_head.addr : '0;
   assign out_grfw  = w_valid ? w_head.data : '0;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_grf_trace_fifo.sv
// Directed bench for grf_trace_fifo with a queue-based scoreboard of expected records.
module tb_grf_trace_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int DROP_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_we;
   logic [31:0]       in_pc;
   logic [4:0]        in_grfa;
   logic [31:0]       in_grfw;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [4:0]        out_grfa;
   logic [31:0]       out_grfw;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;
   logic              clr_ovf;

   grf_trace_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_we     (in_we),
      .in_pc     (in_pc),
      .in_grfa   (in_grfa),
      .in_grfw   (in_grfw),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_grfa  (out_grfa),
      .out_grfw  (out_grfw),
      .count     (count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  a;
      logic [31:0] w;
   } rec_t;

   rec_t        m_q[$];
   logic        m_ovf;
   logic [15:0] m_drop;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] pc, input logic [4:0] a,
                        input logic [31:0] w, input logic rdy, input logic clr);
      in_we     = we;
      in_pc     = pc;
      in_grfa   = a;
      in_grfw   = w;
      out_ready = rdy;
      clr_ovf   = clr;
   endtask

   // Model one clock edge from the inputs currently driven, then check state.
   task automatic tick();
      bit   pr, pp, fl;
      rec_t r;
      pr = in_we && (in_grfa != 5'd0);
      pp = (m_q.size() != 0) && out_ready;
      fl = (m_q.size() == DEPTH);
      if (pp) begin
         r = m_q.pop_front();
         chk("pop_pc", out_pc, r.pc);
         chk("pop_grfa", out_grfa, r.a);
         chk("pop_grfw", out_grfw, r.w);
      end
      if (pr && (!fl || pp)) begin
         r.pc = in_pc; r.a = in_grfa; r.w = in_grfw;
         m_q.push_back(r);
      end
      if (pr && fl && !pp) begin
         m_ovf  = 1'b1;
         m_drop = clr_ovf ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
      end else if (clr_ovf) begin
         m_ovf  = 1'b0;
         m_drop = '0;
      end
      @(posedge clk);
      #1;
      chk("count", count, m_q.size());
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_q.size() == 0) begin
         chk("empty_mask", {out_pc, out_grfa, out_grfw}, 64'd0);
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      m_ovf  = 1'b0;
      m_drop = '0;

      // 1: reset state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_pc", out_pc, 0);
      tick();

      // 2: single push, held, then popped
      drive(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0, 1'b0);
      tick();
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_count", count, 1);
      chk("t2_grfw", out_grfw, 32'h1234);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk("t2_hold", out_grfw, 32'h1234);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();
      chk("t2_cnt0", count, 0);

      // 3: writes to $0 are filtered
      drive(1'b1, 32'h4000, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      repeat (5) tick();
      chk("t3_count", count, 0);
      chk("t3_drop", drop_cnt, 0);

      // empty with ready: push only, no bypass
      drive(1'b1, 32'h4004, 5'd5, 32'h55, 1'b1, 1'b0);
      tick();
      chk("nobypass_cnt", count, 1);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();

      // 4: fill, overflow, drain in order
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 32'h5000 + 32'(i * 4), 5'(i), 32'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h5100, 5'd17, 32'd17, 1'b0, 1'b0);
      tick();
      chk("t4_count", count, 16);
      chk("t4_ovf", overflow, 1'b1);
      chk("t4_drop", drop_cnt, 1);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk("t4_order", out_grfw, 32'(i + 1));
         tick();
      end

      // 5: simultaneous push/pop at full with wrapped pointers
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'h6000 + 32'(i), 5'd9, 32'(101 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h6100, 5'd10, 32'd99, 1'b1, 1'b0);
      tick();
      chk("t5_count", count, 16);
      chk("t5_drop", drop_cnt, 1);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk("t5_order", out_grfw, (i == 15) ? 32'd99 : 32'(102 + i));
         tick();
      end

      // 6: asynchronous reset mid-operation
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 32'h7000, 5'd3, 32'(200 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
      reset = 1'b0;
      #2;
      chk("t6_async_cnt", count, 0);
      chk("t6_async_valid", out_valid, 1'b0);
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) tick();
      chk("t6_flushed", out_valid, 1'b0);

      // clear and drop in the same cycle: drop wins
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'h8000, 5'd4, 32'(300 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h8100, 5'd4, 32'd400, 1'b0, 1'b0);
      repeat (2) tick();
      chk("t6_drop2", drop_cnt, 2);
      drive(1'b1, 32'h8200, 5'd4, 32'd401, 1'b0, 1'b1);
      tick();
      chk("t6_clr_ovf", overflow, 1'b1);
      chk("t6_clr_drop", drop_cnt, 1);
      drive(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      tick();
      chk("t6_clr_only_ovf", overflow, 1'b0);
      chk("t6_clr_only_drop", drop_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
